// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter
// Shares one AXI read slave port between two read masters (M0, M1).
// Round-robin per burst; the grant is held from AR acceptance until the
// RLAST handshake, and R beats are steered back by that held grant because
// the slave only returns the low ID nibble.
// Optional feature: define ARB_TIMEOUT_EN to add a watchdog that ends a
// stalled burst with a SLVERR beat to the granted master.
module axi_read_arbiter #(
  parameter int ID_W        = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                clk,
  input  logic                rst,
  // master 0 read port
  input  logic [ID_W-1:0]     ARID_M0,
  input  logic [ADDR_W-1:0]   ARADDR_M0,
  input  logic [3:0]          ARLEN_M0,
  input  logic [2:0]          ARSIZE_M0,
  input  logic [1:0]          ARBURST_M0,
  input  logic                ARVALID_M0,
  output logic                ARREADY_M0,
  output logic [ID_W-1:0]     RID_M0,
  output logic [DATA_W-1:0]   RDATA_M0,
  output logic [1:0]          RRESP_M0,
  output logic                RLAST_M0,
  output logic                RVALID_M0,
  input  logic                RREADY_M0,
  // master 1 read port
  input  logic [ID_W-1:0]     ARID_M1,
  input  logic [ADDR_W-1:0]   ARADDR_M1,
  input  logic [3:0]          ARLEN_M1,
  input  logic [2:0]          ARSIZE_M1,
  input  logic [1:0]          ARBURST_M1,
  input  logic                ARVALID_M1,
  output logic                ARREADY_M1,
  output logic [ID_W-1:0]     RID_M1,
  output logic [DATA_W-1:0]   RDATA_M1,
  output logic [1:0]          RRESP_M1,
  output logic                RLAST_M1,
  output logic                RVALID_M1,
  input  logic                RREADY_M1,
  // shared slave read port
  output logic [ID_W+3:0]     ARID_S,
  output logic [ADDR_W-1:0]   ARADDR_S,
  output logic [3:0]          ARLEN_S,
  output logic [2:0]          ARSIZE_S,
  output logic [1:0]          ARBURST_S,
  output logic                ARVALID_S,
  input  logic                ARREADY_S,
  input  logic [ID_W+3:0]     RID_S,
  input  logic [DATA_W-1:0]   RDATA_S,
  input  logic [1:0]          RRESP_S,
  input  logic                RLAST_S,
  input  logic                RVALID_S,
  output logic                RREADY_S
);

`ifdef ARB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, ADDR, DATA, TERR} state_t;
`else
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
`endif

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_t              state, state_nxt;
  logic                grant;
  logic                prio;
  logic [ID_W-1:0]     ar_id;
  logic [ADDR_W-1:0]   ar_addr;
  logic [3:0]          ar_len;
  logic [2:0]          ar_size;
  logic [1:0]          ar_burst;

  logic                win;
  logic                accept;
  logic                flip_prio;
  logic                r_hs;
  logic                tmo_hit;
  logic                unused_rid;

  // Only the low nibble of the slave ID belongs to the master.
  assign unused_rid = ^RID_S[ID_W+3:ID_W];

  // The slave AR channel always presents the latched request fields.
  assign ARID_S    = {4'(grant), ar_id};
  assign ARADDR_S  = ar_addr;
  assign ARLEN_S   = ar_len;
  assign ARSIZE_S  = ar_size;
  assign ARBURST_S = ar_burst;

  // Round-robin pick: a lone requester wins; on a tie the pointer decides.
  assign win = (ARVALID_M0 && ARVALID_M1) ? prio : ARVALID_M1;

  // State register, grant/pointer and latched AR fields.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      grant    <= 1'b0;
      prio     <= 1'b0;
      ar_id    <= '0;
      ar_addr  <= '0;
      ar_len   <= '0;
      ar_size  <= '0;
      ar_burst <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        grant    <= win;
        ar_id    <= win ? ARID_M1    : ARID_M0;
        ar_addr  <= win ? ARADDR_M1  : ARADDR_M0;
        ar_len   <= win ? ARLEN_M1   : ARLEN_M0;
        ar_size  <= win ? ARSIZE_M1  : ARSIZE_M0;
        ar_burst <= win ? ARBURST_M1 : ARBURST_M0;
      end
      if (flip_prio) begin
        prio <= ~grant;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] tmo_cnt;

  assign tmo_hit = (state == ADDR || state == DATA) &&
                   (tmo_cnt == CNT_W'(TIMEOUT_CYC));

  // Watchdog: counts stalled cycles in ADDR/DATA, cleared by any progress.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tmo_cnt <= '0;
    end else begin
      case (state)
        ADDR:    tmo_cnt <= ARREADY_S ? '0 : tmo_cnt + 1'b1;
        DATA:    tmo_cnt <= r_hs ? '0 : tmo_cnt + 1'b1;
        default: tmo_cnt <= '0;
      endcase
    end
  end
`else
  logic [CNT_W-1:0] unused_tmo;

  assign unused_tmo = CNT_W'(TIMEOUT_CYC);
  assign tmo_hit    = 1'b0;
`endif

  // Next-state logic, AR handshakes and R-channel steering.
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    flip_prio  = 1'b0;
    r_hs       = 1'b0;
    ARREADY_M0 = 1'b0;
    ARREADY_M1 = 1'b0;
    ARVALID_S  = 1'b0;
    RREADY_S   = 1'b0;
    RID_M0     = '0;
    RDATA_M0   = '0;
    RRESP_M0   = '0;
    RLAST_M0   = 1'b0;
    RVALID_M0  = 1'b0;
    RID_M1     = '0;
    RDATA_M1   = '0;
    RRESP_M1   = '0;
    RLAST_M1   = 1'b0;
    RVALID_M1  = 1'b0;

    if (rst) begin
      case (state)
        IDLE: begin
          if (ARVALID_M0 || ARVALID_M1) begin
            accept     = 1'b1;
            ARREADY_M0 = ~win;
            ARREADY_M1 = win;
            state_nxt  = ADDR;
          end
        end
        ADDR: begin
          if (tmo_hit) begin
`ifdef ARB_TIMEOUT_EN
            state_nxt = TERR;
`endif
          end else begin
            ARVALID_S = 1'b1;
            if (ARREADY_S) begin
              state_nxt = DATA;
            end
          end
        end
        DATA: begin
          if (tmo_hit) begin
`ifdef ARB_TIMEOUT_EN
            state_nxt = TERR;
`endif
          end else begin
            RREADY_S = grant ? RREADY_M1 : RREADY_M0;
            r_hs     = RVALID_S && RREADY_S;
            if (grant) begin
              RID_M1    = RID_S[ID_W-1:0];
              RDATA_M1  = RDATA_S;
              RRESP_M1  = RRESP_S;
              RLAST_M1  = RLAST_S;
              RVALID_M1 = RVALID_S;
            end else begin
              RID_M0    = RID_S[ID_W-1:0];
              RDATA_M0  = RDATA_S;
              RRESP_M0  = RRESP_S;
              RLAST_M0  = RLAST_S;
              RVALID_M0 = RVALID_S;
            end
            if (r_hs && RLAST_S) begin
              flip_prio = 1'b1;
              state_nxt = IDLE;
            end
          end
        end
`ifdef ARB_TIMEOUT_EN
        TERR: begin
          if (grant) begin
            RID_M1    = ar_id;
            RRESP_M1  = 2'b10;
            RLAST_M1  = 1'b1;
            RVALID_M1 = 1'b1;
          end else begin
            RID_M0    = ar_id;
            RRESP_M0  = 2'b10;
            RLAST_M0  = 1'b1;
            RVALID_M0 = 1'b1;
          end
          if (grant ? RREADY_M1 : RREADY_M0) begin
            flip_prio = 1'b1;
            state_nxt = IDLE;
          end
        end
`endif
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule
